// File: rtl/param_mod_counter.sv
// Parametrised up/down modulo-N counter with wrap/saturate, clear, load,
// registered carry/borrow pulse and sticky overflow flag.
module param_mod_counter #(
  parameter int unsigned      WIDTH     = 5,
  parameter longint unsigned  MODULUS   = 32,
  parameter bit               SATURATE  = 1'b0,
  parameter longint unsigned  RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             CD,
  input  logic             EN,
  input  logic             UP,
  input  logic             SCLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO,
  output logic             OVF
);

  // One extra bit so comparisons against MODULUS-1 never alias modulo 2^WIDTH
  localparam int unsigned EW = WIDTH + 1;
  localparam logic [EW-1:0]    MAX_V = EW'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  // Reject illegal parameter combinations at elaboration
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("param_mod_counter: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("param_mod_counter: MODULUS must be in 2..2^WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("param_mod_counter: RESET_VAL must be below MODULUS");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;
  logic [EW-1:0]    q_ext;
  logic [EW-1:0]    d_ext;

  assign q_ext = {1'b0, q_q};
  assign d_ext = {1'b0, D};

  // Next-state selection: clear beats load beats count
  always_comb begin
    q_d     = q_q;
    co_d    = 1'b0;
    ovf_set = 1'b0;
    if (SCLR) begin
      q_d = RST_Q;
    end else if (LD) begin
      if (d_ext > MAX_V) begin
        q_d     = MAX_Q;
        ovf_set = 1'b1;
      end else begin
        q_d = D;
      end
    end else if (EN) begin
      if (UP) begin
        if (q_ext == MAX_V) begin
          co_d    = 1'b1;
          ovf_set = 1'b1;
          if (!SATURATE) q_d = '0;
        end else begin
          q_d = WIDTH'(q_ext + EW'(1));
        end
      end else begin
        if (q_q == '0) begin
          co_d    = 1'b1;
          ovf_set = 1'b1;
          if (!SATURATE) q_d = MAX_Q;
        end else begin
          q_d = WIDTH'(q_ext - EW'(1));
        end
      end
    end
    // A new overflow event outranks a clear request on the same edge
    ovf_d = ovf_set ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);
  end

  // State registers with asynchronous active-high clear
  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      q_q   <= RST_Q;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign CO  = co_q;
  assign OVF = ovf_q;
  // Terminal count is combinational and deliberately ignores SCLR/LD
  assign TC  = EN & (UP ? (q_ext == MAX_V) : (q_q == '0));

endmodule
